// File: rtl/onion_pwm_fader_if.sv
// Control/status bundle between the PWM config register file and one fader channel.
// The register file drives the master side; the fader sits on the slave side.
interface onion_pwm_fader_if #(
    parameter int PWM_RESOLUTION_BITS = 8,
    parameter int PRESCALE_BITS       = 16
);
    logic                           enable_i;
    logic                           mode_i;
    logic [PWM_RESOLUTION_BITS-1:0] target_i;
    logic [PWM_RESOLUTION_BITS-1:0] step_i;
    logic [PRESCALE_BITS-1:0]       tick_div_i;
    logic [PWM_RESOLUTION_BITS-1:0] duty_o;
    logic                           at_target_o;
    logic                           cycle_done_o;

    modport master (
        output enable_i, mode_i, target_i, step_i, tick_div_i,
        input  duty_o, at_target_o, cycle_done_o
    );

    modport slave (
        input  enable_i, mode_i, target_i, step_i, tick_div_i,
        output duty_o, at_target_o, cycle_done_o
    );
endinterface

// File: rtl/onion_pwm_fader.sv
// Duty-cycle ramp engine: steps duty_o toward a target (TRACK) or sweeps 0..target..0
// (BREATHE) once per prescaler tick, with saturating arithmetic throughout.
module onion_pwm_fader #(
    parameter int PWM_RESOLUTION_BITS = 8,
    parameter int PRESCALE_BITS       = 16
) (
    input  logic               WBs_CLK_i,
    input  logic               WBs_RST_i,
    onion_pwm_fader_if.slave   bus
);
    localparam int N = PWM_RESOLUTION_BITS;

    typedef enum logic [1:0] {IDLE, TRACK, UP, DOWN} state_t;

    state_t                   state_q, state_d;
    logic [PRESCALE_BITS-1:0] cnt_q, cnt_d;
    logic [N-1:0]             duty_q, duty_d;
    logic                     at_target_q, at_target_d;
    logic                     cycle_done_q, cycle_done_d;
    logic [N-1:0]             step_eff;
    logic [N-1:0]             up_val;
    logic [N-1:0]             dn_val;
    logic                     tick;

    // min(a + b, lim) using an N+1 bit sum so the carry is never lost
    function automatic logic [N-1:0] sat_add(input logic [N-1:0] a,
                                             input logic [N-1:0] b,
                                             input logic [N-1:0] lim);
        logic [N:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[N-1:0];
    endfunction

    // max(a - b, floor) using an N+1 bit signed difference so a borrow reads as negative
    function automatic logic [N-1:0] sat_sub(input logic [N-1:0] a,
                                             input logic [N-1:0] b,
                                             input logic [N-1:0] floor);
        logic signed [N:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return (diff < $signed({1'b0, floor})) ? floor : diff[N-1:0];
    endfunction

    always_comb begin
        step_eff = (bus.step_i == '0) ? N'(1) : bus.step_i;
        tick     = (state_q != IDLE) && (cnt_q == bus.tick_div_i);
        up_val   = sat_add(duty_q, step_eff, bus.target_i);
        dn_val   = sat_sub(duty_q, step_eff,
                           (state_q == TRACK) ? bus.target_i : '0);

        state_d      = state_q;
        duty_d       = duty_q;
        cnt_d        = cnt_q;
        at_target_d  = 1'b0;
        cycle_done_d = 1'b0;

        if (!bus.enable_i) begin
            state_d = IDLE;
            duty_d  = '0;
            cnt_d   = '0;
        end else begin
            // A count above a freshly lowered divider reloads without ticking
            cnt_d = ((state_q == IDLE) || (cnt_q >= bus.tick_div_i)) ? '0 : cnt_q + 1'b1;
            at_target_d = !bus.mode_i && (state_q == TRACK) && (duty_q == bus.target_i);

            case (state_q)
                IDLE: begin
                    state_d = bus.mode_i ? UP : TRACK;
                    duty_d  = '0;
                end
                TRACK: begin
                    if (bus.mode_i) begin
                        state_d = UP;
                    end else if (tick) begin
                        if (duty_q < bus.target_i)      duty_d = up_val;
                        else if (duty_q > bus.target_i) duty_d = dn_val;
                    end
                end
                UP: begin
                    if (!bus.mode_i) begin
                        state_d = TRACK;
                    end else if (tick) begin
                        if (bus.target_i == '0) begin
                            duty_d = '0;
                        end else if (duty_q > bus.target_i) begin
                            duty_d  = bus.target_i;
                            state_d = DOWN;
                        end else begin
                            duty_d = up_val;
                            if (up_val == bus.target_i) state_d = DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (!bus.mode_i) begin
                        state_d = TRACK;
                    end else if (tick) begin
                        duty_d = dn_val;
                        if (dn_val == '0) begin
                            state_d      = UP;
                            cycle_done_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            duty_q       <= '0;
            at_target_q  <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            duty_q       <= duty_d;
            at_target_q  <= at_target_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign bus.duty_o       = duty_q;
    assign bus.at_target_o  = at_target_q;
    assign bus.cycle_done_o = cycle_done_q;
endmodule

// File: tb/tb_onion_pwm_fader.sv
// Directed bench for onion_pwm_fader: hand-computed duty/flag values checked
// one clock edge at a time, sampled 1 time unit after each rising edge.
module tb_onion_pwm_fader;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    onion_pwm_fader_if #(.PWM_RESOLUTION_BITS(8), .PRESCALE_BITS(16)) bus ();

    onion_pwm_fader #(.PWM_RESOLUTION_BITS(8), .PRESCALE_BITS(16)) dut (
        .WBs_CLK_i (clk),
        .WBs_RST_i (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] br_exp [12];
        compared   = 0;
        mismatched = 0;
        br_exp     = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0,
                       8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0};

        rst = 1'b1;
        bus.enable_i   = 1'b0;
        bus.mode_i     = 1'b0;
        bus.target_i   = 8'h80;
        bus.step_i     = 8'h30;
        bus.tick_div_i = 16'd3;
        clk_n(2);
        check("reset_duty", 16'(bus.duty_o), 16'h00);
        check("reset_at_target", 16'(bus.at_target_o), 16'h0);
        check("reset_cycle_done", 16'(bus.cycle_done_o), 16'h0);

        // TRACK up, tick every 4 clocks
        rst = 1'b0;
        bus.enable_i = 1'b1;
        clk_n(1);
        check("track_entry", 16'(bus.duty_o), 16'h00);
        clk_n(3);
        check("track_pre_tick", 16'(bus.duty_o), 16'h00);
        clk_n(1);
        check("track_up_1", 16'(bus.duty_o), 16'h30);
        clk_n(4);
        check("track_up_2", 16'(bus.duty_o), 16'h60);
        clk_n(4);
        check("track_up_sat", 16'(bus.duty_o), 16'h80);
        check("at_target_lag", 16'(bus.at_target_o), 16'h0);
        clk_n(1);
        check("at_target_set", 16'(bus.at_target_o), 16'h1);
        clk_n(7);
        check("track_hold", 16'(bus.duty_o), 16'h80);
        check("at_target_hold", 16'(bus.at_target_o), 16'h1);

        // TRACK down after retarget
        bus.target_i = 8'h10;
        bus.step_i   = 8'h50;
        clk_n(4);
        check("track_down_1", 16'(bus.duty_o), 16'h30);
        check("at_target_clear", 16'(bus.at_target_o), 16'h0);
        clk_n(4);
        check("track_down_sat", 16'(bus.duty_o), 16'h10);
        clk_n(1);
        check("at_target_low", 16'(bus.at_target_o), 16'h1);
        clk_n(8);
        check("track_low_hold", 16'(bus.duty_o), 16'h10);

        // Reset mid-ramp at 0x40
        bus.target_i = 8'hF0;
        bus.step_i   = 8'h30;
        for (int i = 0; i < 12 && bus.duty_o != 8'h40; i++) clk_n(1);
        check("ramp_reach_40", 16'(bus.duty_o), 16'h40);
        rst = 1'b1;
        clk_n(1);
        rst = 1'b0;
        check("midramp_reset_duty", 16'(bus.duty_o), 16'h00);
        check("midramp_reset_at", 16'(bus.at_target_o), 16'h0);
        clk_n(1);
        check("restart_entry", 16'(bus.duty_o), 16'h00);
        clk_n(3);
        check("restart_pre_tick", 16'(bus.duty_o), 16'h00);
        clk_n(1);
        check("restart_step", 16'(bus.duty_o), 16'h30);

        bus.enable_i = 1'b0;
        clk_n(1);
        check("disable_duty", 16'(bus.duty_o), 16'h00);
        clk_n(1);

        // BREATHE, step 0 acts as 1, tick every clock
        bus.mode_i     = 1'b1;
        bus.step_i     = 8'h00;
        bus.tick_div_i = 16'd0;
        bus.target_i   = 8'h03;
        bus.enable_i   = 1'b1;
        clk_n(1);
        check("breathe_entry", 16'(bus.duty_o), 16'h00);
        check("breathe_entry_cd", 16'(bus.cycle_done_o), 16'h0);
        for (int i = 0; i < 12; i++) begin
            clk_n(1);
            check("breathe_duty", 16'(bus.duty_o), 16'(br_exp[i]));
            check("breathe_cycle_done", 16'(bus.cycle_done_o), 16'(br_exp[i] == 8'd0));
            check("breathe_at_target", 16'(bus.at_target_o), 16'h0);
        end

        // Full-scale breathe
        bus.target_i = 8'hFF;
        bus.step_i   = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            clk_n(1);
            check("fullscale_duty", 16'(bus.duty_o), (i % 2 == 0) ? 16'hFF : 16'h00);
            check("fullscale_cd", 16'(bus.cycle_done_o), (i % 2 == 0) ? 16'h0 : 16'h1);
        end

        // Mode switch to TRACK on a tick edge during DOWN
        bus.target_i   = 8'h80;
        bus.step_i     = 8'h20;
        bus.tick_div_i = 16'd3;
        clk_n(16);
        check("breathe_peak", 16'(bus.duty_o), 16'h80);
        check("breathe_peak_at", 16'(bus.at_target_o), 16'h0);
        clk_n(4);
        check("breathe_down", 16'(bus.duty_o), 16'h60);
        clk_n(3);
        check("pre_mode_edge", 16'(bus.duty_o), 16'h60);
        bus.mode_i = 1'b0;
        clk_n(1);
        check("mode_edge_no_step", 16'(bus.duty_o), 16'h60);
        check("mode_edge_cd", 16'(bus.cycle_done_o), 16'h0);
        clk_n(4);
        check("track_after_mode", 16'(bus.duty_o), 16'h80);
        clk_n(1);
        check("track_after_mode_at", 16'(bus.at_target_o), 16'h1);
        bus.enable_i = 1'b0;
        clk_n(1);
        check("drop_enable_duty", 16'(bus.duty_o), 16'h00);
        check("drop_enable_at", 16'(bus.at_target_o), 16'h0);

        // Restart, then lower the divider below the running count
        bus.enable_i = 1'b1;
        clk_n(1);
        clk_n(2);
        check("lower_div_before", 16'(bus.duty_o), 16'h00);
        bus.tick_div_i = 16'd1;
        clk_n(2);
        check("lower_div_no_tick", 16'(bus.duty_o), 16'h00);
        clk_n(1);
        check("lower_div_tick", 16'(bus.duty_o), 16'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/onion_pwm_fader.md
Name: onion_pwm_fader

Overview:
- Duty-cycle ramp engine between the PWM config register file and the PWM core.
- Converts a software-written target duty into a duty value that steps toward the target at a programmable rate.
- Supports two modes: track-to-target, and continuous breathe (0 up to target, then back down to 0).
- One instance per PWM channel; duty_o drives the PWM core duty_cycle input directly.

Parameters:
- PWM_RESOLUTION_BITS, 8, width of the target, step and duty values.
- PRESCALE_BITS, 16, width of the tick divider.

Ports:
- WBs_CLK_i  input  1  block clock; the only clock.
- WBs_RST_i  input  1  synchronous, active-high reset.
- enable_i  input  1  1 = run, 0 = idle with duty forced to 0.
- mode_i  input  1  0 = TRACK, 1 = BREATHE.
- target_i  input  PWM_RESOLUTION_BITS  target/peak duty.
- step_i  input  PWM_RESOLUTION_BITS  duty increment per tick; 0 is treated as 1.
- tick_div_i  input  PRESCALE_BITS  a tick occurs every tick_div_i+1 clocks.
- duty_o  output  PWM_RESOLUTION_BITS  registered ramped duty.
- at_target_o  output  1  level; TRACK mode only, duty_o equals target_i.
- cycle_done_o  output  1  one-clock pulse at the end of each breathe period.

Behaviour:
- Reset (sync, WBs_RST_i=1 at a clock edge):
  - state=IDLE, prescaler=0, duty_o=0, at_target_o=0, cycle_done_o=0.
  - Reset overrides all other inputs, including mid-ramp.
- Prescaler:
  - Counts 0..tick_div_i; asserts internal tick when count==tick_div_i, then reloads 0.
  - tick_div_i=0 gives a tick every clock.
  - If tick_div_i is lowered below the current count, the next clock reloads 0 and asserts no tick.
  - Prescaler is held at 0 in IDLE.
- States: IDLE, TRACK, UP, DOWN.
- IDLE:
  - duty_o=0, outputs low.
  - When enable_i=1: go to TRACK if mode_i=0, else UP.
  - Prescaler starts on the entry clock.
- Any state, enable_i=0: next clock go to IDLE, duty_o=0.
- Mode change while enabled takes effect next clock, starting from the current duty_o:
  - mode_i 1->0: UP/DOWN -> TRACK.
  - mode_i 0->1: TRACK -> UP.
- Effective step: s = (step_i==0) ? 1 : step_i.
- Arithmetic:
  - Use PWM_RESOLUTION_BITS+1-bit sum and difference.
  - Results saturate at the limit; no wrap-around ever.
- TRACK, on tick:
  - duty<target: duty=min(duty+s, target).
  - duty>target: duty=max(duty-s, target).
  - Equal: hold.
  - at_target_o = (duty_o==target_i), registered; updates the clock after duty_o changes.
  - A target change between ticks is used at the next tick.
- UP, on tick:
  - duty=min(duty+s, target).
  - If the result equals target -> DOWN.
  - If duty>target at entry (target was lowered): duty=target, -> DOWN.
- DOWN, on tick:
  - duty=max(duty-s, 0).
  - When the result is 0 -> UP, and cycle_done_o pulses high for exactly the clock in which duty_o becomes 0.
- BREATHE with target_i=0:
  - duty held 0, state stays UP, no cycle_done_o pulses.
- at_target_o is 0 in UP, DOWN and IDLE.
- Latency: duty_o changes on the clock edge after the tick is asserted, i.e. every tick_div_i+1 clocks.
- Simultaneous events on one edge, priority highest first: reset > enable_i=0 > mode change > tick update.
  - A mode change on a tick edge applies the mode change only; the step is deferred to the next tick.
- Full-scale limits:
  - target_i=2^N-1 with step_i=2^N-1: duty reaches full scale in one tick, no overflow.
  - Descending from full scale saturates at 0.

Test Plan:
- Reset mid-ramp: TRACK, duty=0x40 rising; assert WBs_RST_i 1 clock -> next clock duty_o=0, state IDLE; with enable held, restarts from 0.
- TRACK up with saturation: tick_div=3, step=0x30, target=0x80, from 0 -> duty_o 0x30, 0x60, 0x80 at clocks 4, 8, 12; at_target_o=1 at clock 13; holds.
- TRACK down with retarget: at duty=0x80 set target=0x10, step=0x50 -> 0x30 then 0x10; no underflow.
- BREATHE, step=0, tick_div=0, target=3 -> duty 1,2,3,2,1,0,1,...; cycle_done_o pulses once per 6 clocks, coincident with duty_o becoming 0.
- Full scale: N=8, target=0xFF, step=0xFF, BREATHE -> 0xFF, 0x00 alternating each tick; no wrap; cycle_done_o pulses on each 0.
- Disable and mode switch: during DOWN, set mode_i=0 on a tick edge -> TRACK, no step that tick. Then drop enable_i -> duty_o=0 next clock, prescaler=0, at_target_o=0.
